// File: rtl/i2c_master_byte_ctrl_if.sv
// -----------------------------------------------------------------------------
// i2c_master_byte_ctrl_if
//   Bundles the byte-level command handshake and the bit-controller command
//   bus of the I2C master byte controller.
//
//   Requester side : start/stop/read/write requests, ack_in, din  ->
//                    cmd_ack, ack_out, dout, i2c_al, timeout      <-
//   Bit-ctrl side  : bit_cmd, bit_din                             ->
//                    bit_ack, bit_dout, bit_al                    <-
//
//   modport master : view used by the byte controller itself
//   modport slave  : view used by whatever surrounds it (requester + bit ctrl)
// -----------------------------------------------------------------------------
interface i2c_master_byte_ctrl_if #(
  parameter int BITS = 8
);
  logic            start;
  logic            stop;
  logic            read;
  logic            write;
  logic            ack_in;
  logic [BITS-1:0] din;
  logic            cmd_ack;
  logic            ack_out;
  logic [BITS-1:0] dout;
  logic            i2c_al;
  logic            timeout;
  logic [3:0]      bit_cmd;
  logic            bit_din;
  logic            bit_ack;
  logic            bit_dout;
  logic            bit_al;

  modport master (
    input  start, stop, read, write, ack_in, din,
    input  bit_ack, bit_dout, bit_al,
    output cmd_ack, ack_out, dout, i2c_al, timeout,
    output bit_cmd, bit_din
  );

  modport slave (
    output start, stop, read, write, ack_in, din,
    output bit_ack, bit_dout, bit_al,
    input  cmd_ack, ack_out, dout, i2c_al, timeout,
    input  bit_cmd, bit_din
  );
endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_master_byte_ctrl
//   Byte-level I2C master controller. Turns start/stop/read/write byte requests
//   into a sequence of single-bit commands for an I2C bit controller, shifting
//   BITS data bits out (write) or in (read) MSB first, followed by the ACK bit.
//
// Ports
//   clk  : system clock, all state changes on rising edge
//   rst  : asynchronous, active-high reset
//   bus  : i2c_master_byte_ctrl_if.master
//          start/stop/read/write : requests, held until cmd_ack
//          ack_in  : ACK bit driven after a read byte
//          din     : byte to write
//          cmd_ack : one-cycle completion pulse
//          ack_out : ACK bit received after a write byte
//          dout    : shift register contents
//          i2c_al  : one-cycle arbitration-lost pulse
//          timeout : one-cycle watchdog pulse (0 when watchdog not built)
//          bit_cmd/bit_din            : command to the bit controller
//          bit_ack/bit_dout/bit_al    : response from the bit controller
//
// Build option
//   I2C_BYTE_CTRL_TIMEOUT_EN : adds a 16-bit watchdog that aborts to IDLE when
//                              a non-IDLE state waits 65535 cycles for bit_ack.
// -----------------------------------------------------------------------------
module i2c_master_byte_ctrl #(
  parameter int BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_master_byte_ctrl_if.master bus
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WRITE,
    READ,
    ACK,
    STOP
  } state_t;

  state_t           state_q, state_n;
  logic [3:0]       bit_cmd_q, bit_cmd_n;
  logic             bit_din_q, bit_din_n;
  logic             cmd_ack_q, cmd_ack_n;
  logic             ack_out_q, ack_out_n;
  logic             i2c_al_q, i2c_al_n;
  logic [BITS-1:0]  sr_q, sr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [BITS-1:0]  shifted;
  logic             go;
  logic             wd_expire;

  // A request is not re-accepted in the cycle its own cmd_ack is visible,
  // since the requester only drops it after seeing cmd_ack.
  assign go = (bus.start | bus.stop | bus.read | bus.write) & ~cmd_ack_q;

`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        timeout_q;

  // bit_ack in the same cycle wins over the expiring watchdog.
  assign wd_expire = (state_q != IDLE) && (wd_q == 16'hFFFF) && !bus.bit_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire & ~bus.bit_al;
      if (state_q == IDLE || bus.bit_ack || wd_expire) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 16'd1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cmd_q <= CMD_NOP;
      bit_din_q <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      i2c_al_q  <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_n;
      bit_cmd_q <= bit_cmd_n;
      bit_din_q <= bit_din_n;
      cmd_ack_q <= cmd_ack_n;
      ack_out_q <= ack_out_n;
      i2c_al_q  <= i2c_al_n;
      sr_q      <= sr_n;
      cnt_q     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    bit_cmd_n = bit_cmd_q;
    bit_din_n = bit_din_q;
    cmd_ack_n = 1'b0;
    ack_out_n = ack_out_q;
    i2c_al_n  = 1'b0;
    sr_n      = sr_q;
    cnt_n     = cnt_q;
    shifted   = {sr_q[BITS-2:0], bus.bit_dout};

    if (bus.bit_al) begin
      // Lost arbitration: abandon the byte without completing it.
      state_n   = IDLE;
      bit_cmd_n = CMD_NOP;
      bit_din_n = 1'b0;
      i2c_al_n  = 1'b1;
    end else if (wd_expire) begin
      state_n   = IDLE;
      bit_cmd_n = CMD_NOP;
      bit_din_n = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            sr_n  = bus.din;
            cnt_n = CNT_W'(BITS - 1);
            if (bus.start) begin
              state_n   = START;
              bit_cmd_n = CMD_START;
            end else if (bus.read) begin
              state_n   = READ;
              bit_cmd_n = CMD_READ;
            end else if (bus.write) begin
              state_n   = WRITE;
              bit_cmd_n = CMD_WRITE;
              // Shift register is loaded this same edge, so take MSB from din.
              bit_din_n = bus.din[BITS-1];
            end else begin
              state_n   = STOP;
              bit_cmd_n = CMD_STOP;
            end
          end
        end

        START: begin
          if (bus.bit_ack) begin
            if (bus.read) begin
              state_n   = READ;
              bit_cmd_n = CMD_READ;
            end else if (bus.write) begin
              state_n   = WRITE;
              bit_cmd_n = CMD_WRITE;
              bit_din_n = sr_q[BITS-1];
            end else begin
              state_n   = IDLE;
              bit_cmd_n = CMD_NOP;
              cmd_ack_n = 1'b1;
            end
          end
        end

        WRITE, READ: begin
          if (bus.bit_ack) begin
            sr_n = shifted;
            if (cnt_q != '0) begin
              cnt_n = cnt_q - 1'b1;
              if (state_q == WRITE) begin
                bit_din_n = shifted[BITS-1];
              end
            end else begin
              state_n = ACK;
              if (state_q == READ) begin
                bit_cmd_n = CMD_WRITE;
                bit_din_n = bus.ack_in;
              end else begin
                bit_cmd_n = CMD_READ;
                bit_din_n = 1'b0;
              end
            end
          end
        end

        ACK: begin
          if (bus.bit_ack) begin
            ack_out_n = bus.bit_dout;
            bit_din_n = 1'b0;
            if (bus.stop) begin
              state_n   = STOP;
              bit_cmd_n = CMD_STOP;
            end else begin
              state_n   = IDLE;
              bit_cmd_n = CMD_NOP;
              cmd_ack_n = 1'b1;
            end
          end
        end

        STOP: begin
          if (bus.bit_ack) begin
            state_n   = IDLE;
            bit_cmd_n = CMD_NOP;
            cmd_ack_n = 1'b1;
          end
        end

        default: begin
          state_n   = IDLE;
          bit_cmd_n = CMD_NOP;
        end
      endcase
    end
  end

  assign bus.bit_cmd = bit_cmd_q;
  assign bus.bit_din = bit_din_q;
  assign bus.cmd_ack = cmd_ack_q;
  assign bus.ack_out = ack_out_q;
  assign bus.i2c_al  = i2c_al_q;
  assign bus.dout    = sr_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_byte_ctrl
//   Directed testbench for i2c_master_byte_ctrl. The bench plays both the
//   requester and the bit controller; inputs change and outputs are sampled
//   on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_i2c_master_byte_ctrl;

  localparam int BITS = 8;

  localparam logic [3:0] C_NOP   = 4'b0000;
  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_READ  = 4'b1000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  i2c_master_byte_ctrl_if #(.BITS(BITS)) bus ();

  i2c_master_byte_ctrl #(.BITS(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_req;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  // One-cycle bit_ack from the modelled bit controller.
  task automatic pulse_ack(input logic d);
    bus.bit_dout = d;
    bus.bit_ack  = 1'b1;
    @(negedge clk);
    bus.bit_ack  = 1'b0;
    bus.bit_dout = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_req();
    bus.ack_in   = 1'b0;
    bus.din      = '0;
    bus.bit_ack  = 1'b0;
    bus.bit_dout = 1'b0;
    bus.bit_al   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.bit_cmd !== C_NOP) begin
      errors++; $display("FAIL rst_bit_cmd: got %b expected %b", bus.bit_cmd, C_NOP);
    end
    checks++;
    if ({bus.bit_din, bus.cmd_ack, bus.ack_out, bus.i2c_al, bus.timeout} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b expected 00000",
                         {bus.bit_din, bus.cmd_ack, bus.ack_out, bus.i2c_al, bus.timeout});
    end
    checks++;
    if (bus.dout !== 8'h00) begin
      errors++; $display("FAIL rst_dout: got %h expected 00", bus.dout);
    end
    rst = 1'b0;
    @(negedge clk);
    // bit_ack with nothing in progress must do nothing.
    pulse_ack(1'b1);
    @(negedge clk);
    checks++;
    if ({bus.bit_cmd, bus.cmd_ack, bus.ack_out} !== {C_NOP, 2'b00}) begin
      errors++; $display("FAIL idle_ack_ignored: got %b/%b/%b expected 0000/0/0",
                         bus.bit_cmd, bus.cmd_ack, bus.ack_out);
    end
  endtask

  task automatic test_write;
    logic [7:0] d;
    d = 8'hA5;
    bus.din   = d;
    bus.start = 1'b1;
    bus.write = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.bit_cmd !== C_START) begin
      errors++; $display("FAIL wr_start: got %b expected %b", bus.bit_cmd, C_START);
    end
    @(negedge clk);
    checks++;
    if (bus.bit_cmd !== C_START) begin
      errors++; $display("FAIL wr_start_hold: got %b expected %b", bus.bit_cmd, C_START);
    end
    pulse_ack(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.bit_cmd, bus.bit_din} !== {C_WRITE, d[7-i]}) begin
        errors++; $display("FAIL wr_bit%0d: got %b/%b expected %b/%b",
                           i, bus.bit_cmd, bus.bit_din, C_WRITE, d[7-i]);
      end
      pulse_ack(d[7-i]);
    end
    checks++;
    if (bus.bit_cmd !== C_READ) begin
      errors++; $display("FAIL wr_ack_cmd: got %b expected %b", bus.bit_cmd, C_READ);
    end
    checks++;
    if (bus.dout !== 8'hA5) begin
      errors++; $display("FAIL wr_dout: got %h expected a5", bus.dout);
    end
    checks++;
    if (bus.cmd_ack !== 1'b0) begin
      errors++; $display("FAIL wr_early_ack: got %b expected 0", bus.cmd_ack);
    end
    pulse_ack(1'b0);
    checks++;
    if ({bus.cmd_ack, bus.bit_cmd, bus.ack_out} !== {1'b1, C_NOP, 1'b0}) begin
      errors++; $display("FAIL wr_done: got ack=%b cmd=%b ack_out=%b expected 1/0000/0",
                         bus.cmd_ack, bus.bit_cmd, bus.ack_out);
    end
    // Request still held during the cmd_ack cycle: must not restart.
    @(negedge clk);
    checks++;
    if ({bus.cmd_ack, bus.bit_cmd} !== {1'b0, C_NOP}) begin
      errors++; $display("FAIL wr_no_reaccept: got ack=%b cmd=%b expected 0/0000",
                         bus.cmd_ack, bus.bit_cmd);
    end
    clear_req();
    @(negedge clk);
  endtask

  task automatic test_read;
    logic [7:0] rx;
    rx = 8'hC3;
    bus.din    = 8'h00;
    bus.ack_in = 1'b1;
    bus.read   = 1'b1;
    bus.stop   = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.bit_cmd !== C_READ) begin
        errors++; $display("FAIL rd_bit%0d: got %b expected %b", i, bus.bit_cmd, C_READ);
      end
      pulse_ack(rx[7-i]);
    end
    checks++;
    if ({bus.bit_cmd, bus.bit_din} !== {C_WRITE, 1'b1}) begin
      errors++; $display("FAIL rd_ack_bit: got %b/%b expected %b/1",
                         bus.bit_cmd, bus.bit_din, C_WRITE);
    end
    pulse_ack(1'b1);
    checks++;
    if (bus.bit_cmd !== C_STOP) begin
      errors++; $display("FAIL rd_stop: got %b expected %b", bus.bit_cmd, C_STOP);
    end
    checks++;
    if (bus.dout !== 8'hC3) begin
      errors++; $display("FAIL rd_dout: got %h expected c3", bus.dout);
    end
    checks++;
    if (bus.cmd_ack !== 1'b0) begin
      errors++; $display("FAIL rd_early_ack: got %b expected 0", bus.cmd_ack);
    end
    pulse_ack(1'b0);
    checks++;
    if ({bus.cmd_ack, bus.bit_cmd, bus.ack_out} !== {1'b1, C_NOP, 1'b1}) begin
      errors++; $display("FAIL rd_done: got ack=%b cmd=%b ack_out=%b expected 1/0000/1",
                         bus.cmd_ack, bus.bit_cmd, bus.ack_out);
    end
    clear_req();
    bus.ack_in = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ack !== 1'b0) begin
      errors++; $display("FAIL rd_ack_width: got %b expected 0", bus.cmd_ack);
    end
  endtask

  task automatic test_arb_lost;
    logic [7:0] d;
    d = 8'hA5;
    bus.din   = d;
    bus.write = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) pulse_ack(d[7-i]);
    checks++;
    if ({bus.bit_cmd, bus.bit_din} !== {C_WRITE, d[4]}) begin
      errors++; $display("FAIL al_bit4: got %b/%b expected %b/%b",
                         bus.bit_cmd, bus.bit_din, C_WRITE, d[4]);
    end
    // Arbitration lost together with bit_ack: loss must win.
    bus.bit_al  = 1'b1;
    bus.bit_ack = 1'b1;
    @(negedge clk);
    bus.bit_al  = 1'b0;
    bus.bit_ack = 1'b0;
    checks++;
    if ({bus.i2c_al, bus.bit_cmd, bus.cmd_ack} !== {1'b1, C_NOP, 1'b0}) begin
      errors++; $display("FAIL al_abort: got al=%b cmd=%b ack=%b expected 1/0000/0",
                         bus.i2c_al, bus.bit_cmd, bus.cmd_ack);
    end
    clear_req();
    @(negedge clk);
    checks++;
    if ({bus.i2c_al, bus.cmd_ack} !== 2'b00) begin
      errors++; $display("FAIL al_pulse_width: got al=%b ack=%b expected 0/0",
                         bus.i2c_al, bus.cmd_ack);
    end
    d = 8'h3C;
    bus.din   = d;
    bus.write = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.bit_cmd, bus.bit_din} !== {C_WRITE, d[7-i]}) begin
        errors++; $display("FAIL al_next_bit%0d: got %b/%b expected %b/%b",
                           i, bus.bit_cmd, bus.bit_din, C_WRITE, d[7-i]);
      end
      pulse_ack(d[7-i]);
    end
    pulse_ack(1'b1);
    checks++;
    if ({bus.cmd_ack, bus.ack_out, bus.dout} !== {2'b11, 8'h3C}) begin
      errors++; $display("FAIL al_next_done: got ack=%b ack_out=%b dout=%h expected 1/1/3c",
                         bus.cmd_ack, bus.ack_out, bus.dout);
    end
    clear_req();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] d;
    bus.din  = 8'h00;
    bus.read = 1'b1;
    @(negedge clk);
    repeat (3) pulse_ack(1'b1);
    checks++;
    if ({bus.bit_cmd, bus.dout} !== {C_READ, 8'h07}) begin
      errors++; $display("FAIL mr_pre: got %b/%h expected %b/07", bus.bit_cmd, bus.dout, C_READ);
    end
    // Assert reset between clock edges and look before the next rising edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.bit_cmd !== C_NOP) begin
      errors++; $display("FAIL mr_bit_cmd: got %b expected %b", bus.bit_cmd, C_NOP);
    end
    checks++;
    if ({bus.dout, bus.ack_out, bus.cmd_ack, bus.bit_din, bus.i2c_al, bus.timeout} !== 13'b0) begin
      errors++; $display("FAIL mr_outputs: got dout=%h ack_out=%b ack=%b din=%b al=%b to=%b expected 0",
                         bus.dout, bus.ack_out, bus.cmd_ack, bus.bit_din, bus.i2c_al, bus.timeout);
    end
    clear_req();
    @(negedge clk);
    rst = 1'b0;
    d = 8'h81;
    bus.din   = d;
    bus.write = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.bit_cmd, bus.bit_din} !== {C_WRITE, d[7-i]}) begin
        errors++; $display("FAIL mr_wr_bit%0d: got %b/%b expected %b/%b",
                           i, bus.bit_cmd, bus.bit_din, C_WRITE, d[7-i]);
      end
      pulse_ack(d[7-i]);
    end
    checks++;
    if (bus.bit_cmd !== C_READ) begin
      errors++; $display("FAIL mr_wr_ack_cmd: got %b expected %b", bus.bit_cmd, C_READ);
    end
    pulse_ack(1'b1);
    checks++;
    if ({bus.cmd_ack, bus.ack_out, bus.dout} !== {2'b11, 8'h81}) begin
      errors++; $display("FAIL mr_wr_done: got ack=%b ack_out=%b dout=%h expected 1/1/81",
                         bus.cmd_ack, bus.ack_out, bus.dout);
    end
    clear_req();
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int hit;
    int acks;
    hit  = -1;
    acks = 0;
    bus.din   = 8'hFF;
    bus.write = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.bit_cmd !== C_WRITE) begin
      errors++; $display("FAIL to_accept: got %b expected %b", bus.bit_cmd, C_WRITE);
    end
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
    for (int i = 1; i <= 70000 && hit < 0; i++) begin
      @(negedge clk);
      if (bus.cmd_ack === 1'b1) acks++;
      if (bus.timeout === 1'b1) hit = i;
    end
    checks++;
    if (hit != 65536) begin
      errors++; $display("FAIL to_cycle: got %0d expected 65536", hit);
    end
    checks++;
    if ({bus.bit_cmd, bus.cmd_ack, acks} !== {C_NOP, 1'b0, 32'd0}) begin
      errors++; $display("FAIL to_abort: got cmd=%b ack=%b acks=%0d expected 0000/0/0",
                         bus.bit_cmd, bus.cmd_ack, acks);
    end
    clear_req();
    @(negedge clk);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("FAIL to_width: got %b expected 0", bus.timeout);
    end
`else
    for (int i = 0; i < 66000; i++) begin
      @(negedge clk);
      if (bus.timeout !== 1'b0) hit = i;
      if (bus.cmd_ack === 1'b1) acks++;
    end
    checks++;
    if (hit != -1 || acks != 0) begin
      errors++; $display("FAIL to_absent: got timeout at %0d acks=%0d expected none", hit, acks);
    end
    checks++;
    if (bus.bit_cmd !== C_WRITE) begin
      errors++; $display("FAIL to_still_wait: got %b expected %b", bus.bit_cmd, C_WRITE);
    end
    clear_req();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_read();
    test_arb_lost();
    test_reset_mid_read();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 The block SHALL have parameter BITS, default 8, giving the number of data bits per byte transfer.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have ports start, stop, read, write, input, 1 each, command requests held by the requester until cmd_ack.
REQ-005 The block SHALL have ports ack_in (input, 1, ACK bit sent after a read) and din (input, BITS, byte to write).
REQ-006 The block SHALL have ports cmd_ack (output, 1, one-cycle completion pulse), ack_out (output, 1, ACK bit received after a write) and dout (output, BITS, shift register contents).
REQ-007 The block SHALL have port i2c_al, output, 1, one-cycle arbitration-lost pulse.
REQ-008 The block SHALL have port timeout, output, 1, one-cycle watchdog pulse; tied 0 when the watchdog is compiled out.
REQ-009 The block SHALL have bit-controller ports bit_cmd (output, 4), bit_din (output, 1), bit_ack (input, 1), bit_dout (input, 1) and bit_al (input, 1).

Function
REQ-010 bit_cmd encoding SHALL be NOP=4'b0000, START=4'b0001, STOP=4'b0010, WRITE=4'b0100, READ=4'b1000.
REQ-011 All outputs SHALL be registered, and bit_cmd and bit_din SHALL stay stable until bit_ack is sampled high.
REQ-012 The states SHALL be IDLE, START, WRITE, READ, ACK and STOP.
REQ-013 go SHALL equal (start|stop|read|write) & ~cmd_ack, so a request is never re-accepted during its own cmd_ack cycle.
REQ-014 IDLE on go SHALL load the shift register with din and the bit counter with BITS-1, then branch by priority:
- start: to START, bit_cmd=START
- read: to READ, bit_cmd=READ
- write: to WRITE, bit_cmd=WRITE
- otherwise: to STOP, bit_cmd=STOP
REQ-015 START on bit_ack SHALL go to READ with READ if read is set, else to WRITE with WRITE if write is set, else to IDLE with NOP and pulse cmd_ack.
REQ-016 In WRITE, bit_din SHALL equal the shift register MSB.
REQ-017 In WRITE or READ, on bit_ack the shift register SHALL shift left, taking bit_dout into the LSB.
REQ-018 After the bit_ack shift in WRITE or READ:
- counter nonzero: decrement and reissue the same command
- counter zero: go to ACK, issuing WRITE with bit_din=ack_in for a read, or READ for a write
REQ-019 ACK on bit_ack SHALL capture ack_out<=bit_dout, then go to STOP with bit_cmd=STOP if stop is set, else to IDLE with NOP and pulse cmd_ack.
REQ-020 STOP on bit_ack SHALL go to IDLE with NOP and pulse cmd_ack.
REQ-021 cmd_ack SHALL rise exactly one cycle after the final bit_ack and stay high for exactly one cycle.
REQ-022 bit_al SHALL force IDLE, bit_cmd=NOP and cmd_ack=0, and pulse i2c_al for one cycle, taking priority over a simultaneous bit_ack.
REQ-023 bit_ack while in IDLE SHALL be ignored.
REQ-024 A bit counter underflow SHALL never occur; the counter is BITS-wide minimum, log2 sized.

Reset
REQ-025 Asserting rst SHALL immediately, asynchronously and mid-operation set:
- state to IDLE
- bit_cmd to NOP
- bit_din, cmd_ack, ack_out, i2c_al and timeout to 0
- dout to 0 and the counters to 0
REQ-026 After rst deasserts, the first go SHALL be accepted on the next clock edge.

Configuration
REQ-027 With macro I2C_BYTE_CTRL_TIMEOUT_EN defined, a 16-bit watchdog SHALL count cycles in any non-IDLE state without bit_ack, clearing on each bit_ack.
REQ-028 When the watchdog reaches 16'hFFFF, the block SHALL go to IDLE with bit_cmd=NOP and pulse timeout for one cycle, without pulsing cmd_ack.
REQ-029 Without I2C_BYTE_CTRL_TIMEOUT_EN, the watchdog logic SHALL be absent and timeout SHALL be constant 0.

Verification
REQ-030 start+write with din=8'hA5: bit_cmd sequence START, then WRITE x8 with bit_din 1,0,1,0,0,1,0,1, then READ; bit_dout=0 on the ACK gives ack_out=0 and one cmd_ack pulse.
REQ-031 read+stop with ack_in=1 and bit_dout 1,1,0,0,0,0,1,1: bit_cmd READ x8, then WRITE with bit_din=1, then STOP; dout=8'hC3 and cmd_ack one cycle after the STOP bit_ack.
REQ-032 bit_al asserted on the 4th WRITE bit: i2c_al pulses once, bit_cmd=NOP next cycle, no cmd_ack, and the next go is accepted.
REQ-033 rst asserted mid-READ: outputs reach their reset values without a clock edge, and a new write completes normally after release.
REQ-034 With I2C_BYTE_CTRL_TIMEOUT_EN and bit_ack withheld in WRITE: timeout pulses after 65535 cycles and the block returns to IDLE; without the macro, timeout stays 0 throughout.
